// File: rtl/climate_monitor.sv
// climate_monitor: APB slave buffering DHT11 humidity/temperature samples in a
// circular FIFO, with temperature alarm hysteresis and a level interrupt.
// Optional feature: define CLIMATE_MONITOR_MINMAX_EN to add TEMP_MIN/TEMP_MAX
// tracking registers at 0x14/0x18 (otherwise those addresses read 0).
module climate_monitor #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 14
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [31:0]       PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] humidity,
  input  logic [DATA_W-1:0] temperature,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]          addr;
  logic                access;
  logic                wr_en;
  logic                rd_en;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                overflow;
  logic [15:0]         temp16;
  logic [15:0]         hum16;
  logic [2*DATA_W-1:0] rd_entry;
  logic [31:0]         rdata;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic                ctrl_enable;
  logic                ctrl_irq_en;
  logic [15:0]         temp_hi;
  logic [15:0]         temp_lo;
  logic                ovf;
  logic                alarm;

  logic                unused_bits;

  assign addr     = PADDR[4:0];
  assign access   = PSEL & PENABLE;
  assign wr_en    = access & PWRITE;
  assign rd_en    = access & ~PWRITE;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = sample_valid & ctrl_enable;
  // A pop on an empty FIFO is swallowed so pointers and count stay put.
  assign pop      = rd_en & (addr == 5'h08) & ~empty;
  // Simultaneous pop frees a slot, so only a lone push into a full FIFO drops data.
  assign overflow = push & full & ~pop;
  assign temp16   = 16'(temperature);
  assign hum16    = 16'(humidity);
  assign rd_entry = mem[rd_ptr];
  assign PREADY   = access;
  assign PRDATA   = access ? rdata : 32'h0;

  assign unused_bits = ^{PADDR[31:5], PWDATA[31:16]};

  // Sample storage; contents carry no reset since they are invalid until pushed.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= {temperature, humidity};
  end

  // FIFO pointers and occupancy, with oldest-entry overwrite on overflow.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop || overflow) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop && !full) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Control and threshold registers written over APB.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
      temp_hi     <= 16'hFFFF;
      temp_lo     <= 16'h0000;
    end else if (wr_en) begin
      case (addr)
        5'h00: begin
          ctrl_enable <= PWDATA[0];
          ctrl_irq_en <= PWDATA[1];
        end
        5'h0C:   temp_hi <= PWDATA[15:0];
        5'h10:   temp_lo <= PWDATA[15:0];
        default: ;
      endcase
    end
  end

  // Overflow flag: a new overflow wins over a same-cycle W1C clear.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) ovf <= 1'b0;
    else if (overflow) ovf <= 1'b1;
    else if (wr_en && addr == 5'h04 && PWDATA[7]) ovf <= 1'b0;
  end

  // Alarm hysteresis re-evaluated only when a sample is accepted.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) alarm <= 1'b0;
    else if (push) begin
      if (temp16 > temp_hi) alarm <= 1'b1;
      else if (temp16 < temp_lo) alarm <= 1'b0;
    end
  end

  // Registered interrupt, lagging the alarm/overflow state by one cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) irq <= 1'b0;
    else irq <= ctrl_irq_en & (alarm | ovf);
  end

`ifdef CLIMATE_MONITOR_MINMAX_EN
  logic [15:0] temp_min;
  logic [15:0] temp_max;

  // Running min/max of accepted temperatures; any write to either re-arms both.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      temp_min <= 16'hFFFF;
      temp_max <= 16'h0000;
    end else if (wr_en && (addr == 5'h14 || addr == 5'h18)) begin
      temp_min <= 16'hFFFF;
      temp_max <= 16'h0000;
    end else if (push) begin
      if (temp16 < temp_min) temp_min <= temp16;
      if (temp16 > temp_max) temp_max <= temp16;
    end
  end
`endif

  // Read data mux; unmapped addresses and an empty DATA read return zero.
  always_comb begin
    rdata = 32'h0;
    case (addr)
      5'h00: rdata = {30'h0, ctrl_irq_en, ctrl_enable};
      5'h04: rdata = {23'h0, alarm, ovf, full, empty, 5'(count)};
      5'h08: if (!empty) rdata = {16'(rd_entry[2*DATA_W-1:DATA_W]),
                                  16'(rd_entry[DATA_W-1:0])};
      5'h0C: rdata = {16'h0, temp_hi};
      5'h10: rdata = {16'h0, temp_lo};
`ifdef CLIMATE_MONITOR_MINMAX_EN
      5'h14: rdata = {16'h0, temp_min};
      5'h18: rdata = {16'h0, temp_max};
`endif
      default: rdata = 32'h0;
    endcase
  end

  logic unused_hum16;
  assign unused_hum16 = ^hum16;

endmodule

// File: tb/tb_climate_monitor.sv
// tb_climate_monitor: directed self-checking bench for climate_monitor.
// Honours CLIMATE_MONITOR_MINMAX_EN when choosing TEMP_MIN/TEMP_MAX expectations.
module tb_climate_monitor;

  logic        PCLK;
  logic        PRESET;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        sample_valid;
  logic [13:0] humidity;
  logic [13:0] temperature;
  logic        irq;

  int tests_run;
  int tests_failed;

  climate_monitor #(.FIFO_DEPTH(8), .DATA_W(14)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .sample_valid(sample_valid), .humidity(humidity),
    .temperature(temperature), .irq(irq)
  );

  // Free-running 100 MHz clock.
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // All tasks start and end 1ns after a rising edge.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read_push(input logic [31:0] addr, input logic with_push,
                               input logic [13:0] hum, input logic [13:0] temp,
                               output logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (with_push) begin
      sample_valid = 1'b1; humidity = hum; temperature = temp;
    end
    #1 data = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    apb_read_push(addr, 1'b0, 14'd0, 14'd0, data);
  endtask

  task automatic push_sample(input logic [13:0] hum, input logic [13:0] temp);
    sample_valid = 1'b1; humidity = hum; temperature = temp;
    @(posedge PCLK); #1;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    tests_run++;
    if (PREADY !== 1'b0 || PRDATA !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: pready=%b prdata=%h irq=%b, expected 0/0/0", PREADY, PRDATA, irq);
    end
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 32'h0C;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    tests_run++;
    if (PREADY !== 1'b1 || PRDATA !== 32'h0000FFFF) begin
      tests_failed++;
      $display("[TB] FAIL reset_temp_hi: pready=%b prdata=%h, expected 1/0000ffff", PREADY, PRDATA);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    begin
      logic [31:0] rd;
      apb_read(32'h00, rd);
      tests_run++;
      if (rd !== 32'h0) begin
        tests_failed++; $display("[TB] FAIL reset_ctrl: got %h expected 00000000", rd);
      end
      apb_read(32'h04, rd);
      tests_run++;
      if (rd !== 32'h20) begin
        tests_failed++; $display("[TB] FAIL reset_status: got %h expected 00000020", rd);
      end
      apb_read(32'h10, rd);
      tests_run++;
      if (rd !== 32'h0) begin
        tests_failed++; $display("[TB] FAIL reset_temp_lo: got %h expected 00000000", rd);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    apb_write(32'h00, 32'h1);
    push_sample(14'd40, 14'd2350);
    push_sample(14'd41, 14'd2360);
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h02) begin
      tests_failed++; $display("[TB] FAIL basic_count: got %h expected 00000002", rd);
    end
    apb_read(32'h08, rd);
    tests_run++;
    if (rd !== 32'h092E0028) begin
      tests_failed++; $display("[TB] FAIL basic_data0: got %h expected 092e0028", rd);
    end
    apb_read(32'h08, rd);
    tests_run++;
    if (rd !== 32'h09380029) begin
      tests_failed++; $display("[TB] FAIL basic_data1: got %h expected 09380029", rd);
    end
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h20) begin
      tests_failed++; $display("[TB] FAIL basic_empty: got %h expected 00000020", rd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [31:0] exp;
    for (int i = 1; i <= 9; i++) push_sample(14'(10 * i), 14'(i));
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'hC8) begin
      tests_failed++; $display("[TB] FAIL ovf_status: got %h expected 000000c8", rd);
    end
    apb_read(32'h08, rd);
    tests_run++;
    if (rd !== 32'h00020014) begin
      tests_failed++; $display("[TB] FAIL ovf_first_data: got %h expected 00020014", rd);
    end
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h87) begin
      tests_failed++; $display("[TB] FAIL ovf_after_pop: got %h expected 00000087", rd);
    end
    apb_write(32'h04, 32'h80);
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h07) begin
      tests_failed++; $display("[TB] FAIL ovf_w1c: got %h expected 00000007", rd);
    end
    for (int i = 3; i <= 9; i++) begin
      apb_read(32'h08, rd);
      exp = {16'(i), 16'(10 * i)};
      tests_run++;
      if (rd !== exp) begin
        tests_failed++; $display("[TB] FAIL ovf_drain%0d: got %h expected %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) push_sample(14'd50, 14'(100 + i));
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h48) begin
      tests_failed++; $display("[TB] FAIL b2b_full: got %h expected 00000048", rd);
    end
    apb_read_push(32'h08, 1'b1, 14'd60, 14'd200, rd);
    tests_run++;
    if (rd !== 32'h00640032) begin
      tests_failed++; $display("[TB] FAIL b2b_oldest: got %h expected 00640032", rd);
    end
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h48) begin
      tests_failed++; $display("[TB] FAIL b2b_status: got %h expected 00000048", rd);
    end
    for (int i = 0; i < 8; i++) begin
      apb_read(32'h08, rd);
      exp = (i < 7) ? {16'(101 + i), 16'd50} : {16'd200, 16'd60};
      tests_run++;
      if (rd !== exp) begin
        tests_failed++; $display("[TB] FAIL b2b_drain%0d: got %h expected %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_empty();
    logic [31:0] rd;
    apb_read(32'h08, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL empty_data: got %h expected 00000000", rd);
    end
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h20) begin
      tests_failed++; $display("[TB] FAIL empty_status: got %h expected 00000020", rd);
    end
    push_sample(14'd7, 14'd77);
    apb_write(32'h00, 32'h0);
    push_sample(14'd8, 14'd88);
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h01) begin
      tests_failed++; $display("[TB] FAIL disabled_push: got %h expected 00000001", rd);
    end
    apb_read(32'h08, rd);
    tests_run++;
    if (rd !== 32'h004D0007) begin
      tests_failed++; $display("[TB] FAIL disabled_keep: got %h expected 004d0007", rd);
    end
  endtask

  task automatic test_alarm();
    logic [31:0] rd;
    logic [13:0] temps [4] = '{14'd2900, 14'd3001, 14'd2900, 14'd2799};
    logic        alarm_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        irq_prev;
    apb_write(32'h0C, 32'd3000);
    apb_write(32'h10, 32'd2800);
    apb_write(32'h00, 32'h3);
    irq_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_sample(14'd30, temps[i]);
      tests_run++;
      if (irq !== irq_prev) begin
        tests_failed++; $display("[TB] FAIL alarm_irq_lag%0d: got %b expected %b", i, irq, irq_prev);
      end
      @(posedge PCLK); #1;
      tests_run++;
      if (irq !== alarm_exp[i]) begin
        tests_failed++; $display("[TB] FAIL alarm_irq%0d: got %b expected %b", i, irq, alarm_exp[i]);
      end
      irq_prev = alarm_exp[i];
      apb_read(32'h04, rd);
      tests_run++;
      if (rd !== {23'h0, alarm_exp[i], 3'b000, 5'(i + 1)}) begin
        tests_failed++;
        $display("[TB] FAIL alarm_status%0d: got %h expected %h", i, rd, {23'h0, alarm_exp[i], 3'b000, 5'(i + 1)});
      end
    end
    for (int i = 0; i < 4; i++) apb_read(32'h08, rd);
  endtask

  task automatic test_minmax();
    logic [31:0] rd;
    logic [31:0] exp_min;
    logic [31:0] exp_max;
`ifdef CLIMATE_MONITOR_MINMAX_EN
    exp_min = 32'd2100;
    exp_max = 32'd2700;
`else
    exp_min = 32'd0;
    exp_max = 32'd0;
`endif
    apb_write(32'h00, 32'h1);
    apb_write(32'h14, 32'h0);
    push_sample(14'd1, 14'd2500);
    push_sample(14'd2, 14'd2100);
    push_sample(14'd3, 14'd2700);
    apb_read(32'h14, rd);
    tests_run++;
    if (rd !== exp_min) begin
      tests_failed++; $display("[TB] FAIL temp_min: got %h expected %h", rd, exp_min);
    end
    apb_read(32'h18, rd);
    tests_run++;
    if (rd !== exp_max) begin
      tests_failed++; $display("[TB] FAIL temp_max: got %h expected %h", rd, exp_max);
    end
    for (int i = 0; i < 3; i++) apb_read(32'h08, rd);
    apb_read(32'h1C, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd);
    end
    apb_write(32'h1C, 32'hFFFFFFFF);
    apb_read(32'h00, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++; $display("[TB] FAIL unmapped_write: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd;
    push_sample(14'd5, 14'd55);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h1234;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    #1 PRESET = 1'b0;
    @(posedge PCLK); #1;
    apb_read(32'h10, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL midreset_temp_lo: got %h expected 00000000", rd);
    end
    apb_read(32'h04, rd);
    tests_run++;
    if (rd !== 32'h20) begin
      tests_failed++; $display("[TB] FAIL midreset_status: got %h expected 00000020", rd);
    end
  endtask

  // Test sequence.
  initial begin
    tests_run = 0; tests_failed = 0;
    PRESET = 1'b1; PADDR = 32'h0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = 32'h0; sample_valid = 1'b0; humidity = '0; temperature = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_empty();
    test_alarm();
    test_minmax();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
